// File: rtl/axis_tx_arb.sv
// Packet-level round-robin arbiter sharing one 64-bit Tx AXIS master between two sources.
// Optional per-port packet/abort counters are compiled in with AXIS_TX_ARB_STATS_EN.
module axis_tx_arb #(
   parameter int GAP_CYCLES = 0
) (
   input  logic        clk,
   input  logic        tx_axis_aresetn,
   input  logic [63:0] s0_axis_tdata,
   input  logic [7:0]  s0_axis_tkeep,
   input  logic        s0_axis_tvalid,
   output logic        s0_axis_tready,
   input  logic        s0_axis_tlast,
   input  logic        s0_axis_tuser,
   input  logic [63:0] s1_axis_tdata,
   input  logic [7:0]  s1_axis_tkeep,
   input  logic        s1_axis_tvalid,
   output logic        s1_axis_tready,
   input  logic        s1_axis_tlast,
   input  logic        s1_axis_tuser,
   output logic [63:0] tx_axis_tdata,
   output logic [7:0]  tx_axis_tkeep,
   output logic        tx_axis_tvalid,
   input  logic        tx_axis_tready,
   output logic        tx_axis_tlast,
   output logic        tx_axis_tuser,
   output logic [1:0]  grant
`ifdef AXIS_TX_ARB_STATS_EN
   ,
   output logic [31:0] pkts_s0,
   output logic [31:0] pkts_s1,
   output logic [31:0] aborts_s0,
   output logic [31:0] aborts_s1
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, GAP = 2'd2} state_e;

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   state_e          state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic            last_q, last_d;
   logic            started_q, started_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

   logic [63:0]     sel_data;
   logic [7:0]      sel_keep;
   logic            sel_valid, sel_last, sel_user;
   logic            in_pass, beat, end_abort, end_good, end_under, pkt_end, pick1;

   // grant_q[1] selects port 1; in PASS exactly one grant bit is set
   always_comb begin
      sel_data  = grant_q[1] ? s1_axis_tdata  : s0_axis_tdata;
      sel_keep  = grant_q[1] ? s1_axis_tkeep  : s0_axis_tkeep;
      sel_valid = grant_q[1] ? s1_axis_tvalid : s0_axis_tvalid;
      sel_last  = grant_q[1] ? s1_axis_tlast  : s0_axis_tlast;
      sel_user  = grant_q[1] ? s1_axis_tuser  : s0_axis_tuser;
   end

   assign in_pass   = (state_q == PASS);
   assign beat      = in_pass & sel_valid & tx_axis_tready;
   assign end_abort = beat & sel_user;
   assign end_good  = beat & ~sel_user & sel_last;
   assign end_under = in_pass & started_q & ~sel_valid;
   assign pkt_end   = end_abort | end_good | end_under;
   assign pick1     = s1_axis_tvalid & ~(s0_axis_tvalid & last_q);

   always_ff @(posedge clk) begin
      if (!tx_axis_aresetn) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= 1'b1;
         started_q <= 1'b0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         started_q <= started_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      started_d = started_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         IDLE: begin
            if (s0_axis_tvalid | s1_axis_tvalid) begin
               grant_d   = pick1 ? 2'b10 : 2'b01;
               last_d    = pick1;
               started_d = 1'b0;
               state_d   = PASS;
            end
         end
         PASS: begin
            if (beat) started_d = 1'b1;
            if (pkt_end) begin
               grant_d = '0;
               if (GAP_CYCLES > 0) begin
                  state_d   = GAP;
                  gap_cnt_d = GAP_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) state_d = IDLE;
            else gap_cnt_d = gap_cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_axis_tdata  = '0;
      tx_axis_tkeep  = '0;
      tx_axis_tvalid = 1'b0;
      tx_axis_tlast  = 1'b0;
      tx_axis_tuser  = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      if (in_pass) begin
         tx_axis_tdata  = sel_data;
         tx_axis_tkeep  = sel_keep;
         tx_axis_tvalid = sel_valid;
         tx_axis_tlast  = sel_last;
         tx_axis_tuser  = sel_user;
         s0_axis_tready = ~grant_q[1] & tx_axis_tready;
         s1_axis_tready = grant_q[1] & tx_axis_tready;
      end
   end

   assign grant = grant_q;

`ifdef AXIS_TX_ARB_STATS_EN
   logic [31:0] pkts_s0_q, pkts_s1_q, aborts_s0_q, aborts_s1_q;

   always_ff @(posedge clk) begin
      if (!tx_axis_aresetn) begin
         pkts_s0_q   <= '0;
         pkts_s1_q   <= '0;
         aborts_s0_q <= '0;
         aborts_s1_q <= '0;
      end else begin
         if (end_good & ~grant_q[1]) pkts_s0_q <= pkts_s0_q + 32'd1;
         if (end_good & grant_q[1])  pkts_s1_q <= pkts_s1_q + 32'd1;
         if ((end_abort | end_under) & ~grant_q[1]) aborts_s0_q <= aborts_s0_q + 32'd1;
         if ((end_abort | end_under) & grant_q[1])  aborts_s1_q <= aborts_s1_q + 32'd1;
      end
   end

   assign pkts_s0   = pkts_s0_q;
   assign pkts_s1   = pkts_s1_q;
   assign aborts_s0 = aborts_s0_q;
   assign aborts_s1 = aborts_s1_q;
`endif

endmodule

// File: tb/tb_axis_tx_arb.sv
// Directed bench for axis_tx_arb: a cycle table on a GAP_CYCLES=0 instance plus
// hand sequences for gap timing (GAP_CYCLES=3), mid-packet reset and a multi-packet stream.
module tb_axis_tx_arb;

   logic        clk = 1'b0;
   logic        rstn;
   logic [63:0] s0_tdata, s1_tdata;
   logic [7:0]  s0_tkeep, s1_tkeep;
   logic        s0_tvalid, s0_tlast, s0_tuser, s1_tvalid, s1_tlast, s1_tuser;
   logic        m_tready;

   logic [63:0] a_tdata, b_tdata;
   logic [7:0]  a_tkeep, b_tkeep;
   logic        a_tvalid, a_tlast, a_tuser, a_s0rdy, a_s1rdy;
   logic        b_tvalid, b_tlast, b_tuser, b_s0rdy, b_s1rdy;
   logic [1:0]  a_grant, b_grant;
`ifdef AXIS_TX_ARB_STATS_EN
   logic [31:0] a_pk0, a_pk1, a_ab0, a_ab1, b_pk0, b_pk1, b_ab0, b_ab1;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axis_tx_arb #(.GAP_CYCLES(0)) dut_a (
      .clk(clk), .tx_axis_aresetn(rstn),
      .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tvalid(s0_tvalid),
      .s0_axis_tready(a_s0rdy), .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
      .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tvalid(s1_tvalid),
      .s1_axis_tready(a_s1rdy), .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
      .tx_axis_tdata(a_tdata), .tx_axis_tkeep(a_tkeep), .tx_axis_tvalid(a_tvalid),
      .tx_axis_tready(m_tready), .tx_axis_tlast(a_tlast), .tx_axis_tuser(a_tuser),
      .grant(a_grant)
`ifdef AXIS_TX_ARB_STATS_EN
      , .pkts_s0(a_pk0), .pkts_s1(a_pk1), .aborts_s0(a_ab0), .aborts_s1(a_ab1)
`endif
   );

   axis_tx_arb #(.GAP_CYCLES(3)) dut_b (
      .clk(clk), .tx_axis_aresetn(rstn),
      .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tvalid(s0_tvalid),
      .s0_axis_tready(b_s0rdy), .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
      .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tvalid(s1_tvalid),
      .s1_axis_tready(b_s1rdy), .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
      .tx_axis_tdata(b_tdata), .tx_axis_tkeep(b_tkeep), .tx_axis_tvalid(b_tvalid),
      .tx_axis_tready(m_tready), .tx_axis_tlast(b_tlast), .tx_axis_tuser(b_tuser),
      .grant(b_grant)
`ifdef AXIS_TX_ARB_STATS_EN
      , .pkts_s0(b_pk0), .pkts_s1(b_pk1), .aborts_s0(b_ab0), .aborts_s1(b_ab1)
`endif
   );

   // in  = {v0,l0,u0, v1,l1,u1, tready}; exp = {grant[1:0], tvalid,tlast,tuser, rdy0,rdy1}
   typedef struct {
      logic [6:0] in;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [6:0] exp;
      logic [7:0] td;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t V(input logic [6:0] in, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [6:0] exp, input logic [7:0] td);
      vec_t v;
      v.in = in; v.d0 = d0; v.d1 = d1; v.exp = exp; v.td = td;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive(input logic [6:0] in, input logic [7:0] d0, input logic [7:0] d1);
      s0_tvalid = in[6]; s0_tlast = in[5]; s0_tuser = in[4];
      s1_tvalid = in[3]; s1_tlast = in[2]; s1_tuser = in[1];
      m_tready  = in[0];
      s0_tdata  = {8{d0}};
      s1_tdata  = {8{d1}};
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      drive(7'b000_000_1, 8'h00, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      vec_t v;
      logic [7:0] kexp;
      int beat;
      int p0, b0, p1, b1, cyc;
      int order[$];
      int exp_order[6];

      rstn = 1'b0;
      s0_tkeep = 8'hFF;
      s1_tkeep = 8'h0F;
      drive(7'b100_100_1, 8'hEE, 8'hDD);

      // reset held with both sources valid: everything must stay quiet
      repeat (2) @(negedge clk);
      #2;
      chk("rst_grant_a", a_grant, 2'b00);
      chk("rst_tvalid_a", a_tvalid, 1'b0);
      chk("rst_tdata_a", a_tdata, 64'h0);
      chk("rst_rdy_a", {a_s0rdy, a_s1rdy}, 2'b00);
      chk("rst_grant_b", b_grant, 2'b00);
      chk("rst_rdy_b", {b_s0rdy, b_s1rdy}, 2'b00);

      tbl.push_back(V(7'b100_100_1, 8'h01, 8'h11, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b100_100_1, 8'h01, 8'h11, 7'b01_100_10, 8'h01));
      tbl.push_back(V(7'b100_100_1, 8'h02, 8'h11, 7'b01_100_10, 8'h02));
      tbl.push_back(V(7'b110_100_1, 8'h03, 8'h11, 7'b01_110_10, 8'h03));
      tbl.push_back(V(7'b000_100_1, 8'h00, 8'h11, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b000_100_1, 8'h00, 8'h11, 7'b10_100_01, 8'h11));
      tbl.push_back(V(7'b000_100_1, 8'h00, 8'h12, 7'b10_100_01, 8'h12));
      tbl.push_back(V(7'b000_110_1, 8'h00, 8'h13, 7'b10_110_01, 8'h13));
      tbl.push_back(V(7'b000_000_1, 8'h00, 8'h00, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b000_100_1, 8'h00, 8'h21, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b000_100_1, 8'h00, 8'h21, 7'b10_100_01, 8'h21));
      tbl.push_back(V(7'b000_101_1, 8'h00, 8'h22, 7'b10_101_01, 8'h22));
      tbl.push_back(V(7'b000_100_1, 8'h00, 8'h23, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b000_100_1, 8'h00, 8'h23, 7'b10_100_01, 8'h23));
      tbl.push_back(V(7'b000_110_1, 8'h00, 8'h24, 7'b10_110_01, 8'h24));
      tbl.push_back(V(7'b000_000_1, 8'h00, 8'h00, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b100_000_1, 8'h31, 8'h00, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b000_000_1, 8'h31, 8'h00, 7'b01_000_10, 8'h31));
      tbl.push_back(V(7'b100_000_1, 8'h31, 8'h00, 7'b01_100_10, 8'h31));
      tbl.push_back(V(7'b100_000_1, 8'h32, 8'h00, 7'b01_100_10, 8'h32));
      tbl.push_back(V(7'b000_000_1, 8'h33, 8'h00, 7'b01_000_10, 8'h33));
      tbl.push_back(V(7'b000_000_1, 8'h00, 8'h00, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b000_100_1, 8'h00, 8'h41, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b000_100_1, 8'h00, 8'h41, 7'b10_100_01, 8'h41));
      tbl.push_back(V(7'b000_100_0, 8'h00, 8'h42, 7'b10_100_00, 8'h42));
      tbl.push_back(V(7'b000_000_0, 8'h00, 8'h42, 7'b10_000_00, 8'h42));
      tbl.push_back(V(7'b000_000_1, 8'h00, 8'h00, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b100_100_1, 8'h51, 8'h61, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b110_100_1, 8'h51, 8'h61, 7'b01_110_10, 8'h51));
      tbl.push_back(V(7'b100_100_1, 8'h52, 8'h61, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b100_110_1, 8'h52, 8'h61, 7'b10_110_01, 8'h61));
      tbl.push_back(V(7'b110_000_1, 8'h52, 8'h00, 7'b00_000_00, 8'h00));
      tbl.push_back(V(7'b110_000_1, 8'h52, 8'h00, 7'b01_110_10, 8'h52));
      tbl.push_back(V(7'b000_000_1, 8'h00, 8'h00, 7'b00_000_00, 8'h00));

      // table runs on dut_a straight out of reset (last_grant = port 1)
      @(negedge clk);
      rstn = 1'b1;
      drive(7'b000_000_1, 8'h00, 8'h00);
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         @(negedge clk);
         drive(v.in, v.d0, v.d1);
         #2;
         kexp = (v.exp[6:5] == 2'b01) ? 8'hFF : (v.exp[6:5] == 2'b10) ? 8'h0F : 8'h00;
         chk($sformatf("v%0d_grant", i), a_grant, v.exp[6:5]);
         chk($sformatf("v%0d_tvalid", i), a_tvalid, v.exp[4]);
         chk($sformatf("v%0d_tlast", i), a_tlast, v.exp[3]);
         chk($sformatf("v%0d_tuser", i), a_tuser, v.exp[2]);
         chk($sformatf("v%0d_rdy", i), {a_s0rdy, a_s1rdy}, v.exp[1:0]);
         chk($sformatf("v%0d_tdata", i), a_tdata, {8{v.td}});
         chk($sformatf("v%0d_tkeep", i), a_tkeep, kexp);
      end
`ifdef AXIS_TX_ARB_STATS_EN
      chk("tbl_pkts_s0", a_pk0, 32'd3);
      chk("tbl_pkts_s1", a_pk1, 32'd3);
      chk("tbl_aborts_s0", a_ab0, 32'd1);
      chk("tbl_aborts_s1", a_ab1, 32'd2);
`endif

      // GAP_CYCLES=3 with tready toggling 1,0,1,0 over a 4-beat s0 packet
      do_reset();
      @(negedge clk);
      drive(7'b100_100_1, 8'h71, 8'h81);
      #2;
      chk("gap_idle_grant", b_grant, 2'b00);
      beat = 1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive({1'b1, (beat == 4), 1'b0, 3'b100, (i % 2 == 0)}, 8'(8'h70 + beat), 8'h81);
         #2;
         chk($sformatf("gap_p%0d_grant", i), b_grant, 2'b01);
         chk($sformatf("gap_p%0d_tvalid", i), b_tvalid, 1'b1);
         chk($sformatf("gap_p%0d_tdata", i), b_tdata, {8{8'(8'h70 + beat)}});
         chk($sformatf("gap_p%0d_tkeep", i), b_tkeep, 8'hFF);
         chk($sformatf("gap_p%0d_tlast", i), b_tlast, (beat == 4));
         chk($sformatf("gap_p%0d_tuser", i), b_tuser, 1'b0);
         chk($sformatf("gap_p%0d_rdy", i), {b_s0rdy, b_s1rdy}, {m_tready, 1'b0});
         if (m_tready) beat++;
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(7'b000_100_1, 8'h00, 8'h81);
         #2;
         chk($sformatf("gap_b%0d_grant", i), b_grant, 2'b00);
         chk($sformatf("gap_b%0d_tvalid", i), b_tvalid, 1'b0);
         chk($sformatf("gap_b%0d_rdy", i), {b_s0rdy, b_s1rdy}, 2'b00);
      end
      @(negedge clk);
      drive(7'b000_100_1, 8'h00, 8'h81);
      #2;
      chk("gap_next_grant", b_grant, 2'b10);
      chk("gap_next_tdata", b_tdata, {8{8'h81}});
`ifdef AXIS_TX_ARB_STATS_EN
      chk("gap_pkts_s0", b_pk0, 32'd1);
      chk("gap_aborts", {b_ab0, b_ab1, b_pk1}, 96'h0);
`endif

      // reset on beat 2 of a 5-beat s0 packet
      do_reset();
      @(negedge clk);
      drive(7'b100_000_1, 8'h91, 8'h00);
      @(negedge clk);
      drive(7'b100_000_1, 8'h91, 8'h00);
      #2;
      chk("rmid_b1_grant", a_grant, 2'b01);
      @(negedge clk);
      rstn = 1'b0;
      drive(7'b100_000_1, 8'h92, 8'h00);
      #2;
      chk("rmid_b2_tdata", a_tdata, {8{8'h92}});
      @(negedge clk);
      drive(7'b100_100_1, 8'h93, 8'hA1);
      #2;
      chk("rmid_rst_grant", a_grant, 2'b00);
      chk("rmid_rst_tvalid", a_tvalid, 1'b0);
      chk("rmid_rst_tdata", a_tdata, 64'h0);
      chk("rmid_rst_rdy", {a_s0rdy, a_s1rdy}, 2'b00);
`ifdef AXIS_TX_ARB_STATS_EN
      chk("rmid_rst_stats", {a_pk0, a_pk1, a_ab0, a_ab1}, 128'h0);
`endif
      @(negedge clk);
      rstn = 1'b1;
      drive(7'b100_100_1, 8'h93, 8'hA1);
      #2;
      chk("rmid_idle_grant", a_grant, 2'b00);
      @(negedge clk);
      drive(7'b100_100_1, 8'h93, 8'hA1);
      #2;
      chk("rmid_tie_grant", a_grant, 2'b01);
      chk("rmid_tie_tdata", a_tdata, {8{8'h93}});

      // stream: s0 has four 2-beat packets, s1 two, both offered continuously
      do_reset();
      p0 = 0; b0 = 0; p1 = 0; b1 = 0; cyc = 0;
      exp_order = '{0, 1, 0, 1, 0, 0};
      while ((p0 < 4 || p1 < 2) && cyc < 200) begin
         @(negedge clk);
         m_tready  = 1'b1;
         s0_tvalid = (p0 < 4); s0_tlast = (b0 == 1); s0_tuser = 1'b0;
         s1_tvalid = (p1 < 2); s1_tlast = (b1 == 1); s1_tuser = 1'b0;
         s0_tdata  = {8{8'(16 * p0 + b0)}};
         s1_tdata  = {8{8'(8'h80 + 16 * p1 + b1)}};
         #2;
         if (s0_tvalid && a_s0rdy) begin
            chk($sformatf("str_s0_p%0d_b%0d", p0, b0), a_tdata, s0_tdata);
            if (b0 == 1) begin order.push_back(0); b0 = 0; p0++; end
            else b0++;
         end
         if (s1_tvalid && a_s1rdy) begin
            chk($sformatf("str_s1_p%0d_b%0d", p1, b1), a_tdata, s1_tdata);
            if (b1 == 1) begin order.push_back(1); b1 = 0; p1++; end
            else b1++;
         end
         cyc++;
      end
      chk("str_done", (p0 == 4 && p1 == 2), 1'b1);
      chk("str_order_len", order.size(), 6);
      for (int i = 0; i < 6 && i < order.size(); i++)
         chk($sformatf("str_order%0d", i), order[i], exp_order[i]);
      @(negedge clk);
      drive(7'b000_000_1, 8'h00, 8'h00);
      @(negedge clk);
      #2;
      chk("str_end_grant", a_grant, 2'b00);
`ifdef AXIS_TX_ARB_STATS_EN
      chk("str_pkts_s0", a_pk0, 32'd4);
      chk("str_pkts_s1", a_pk1, 32'd2);
      chk("str_aborts", {a_ab0, a_ab1}, 64'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
